// File: rtl/mult_arb_pkg.sv
// Shared widths, FSM state encoding and defaults for the multiplier arbiter.
// Widths match the 8x8->14 `mult` unit that the arbiter fronts.
package mult_arb_pkg;

    localparam int OP_W            = 8;
    localparam int RES_W           = 14;
    localparam int DEF_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT
    } arb_state_t;

    // Width of a requester index; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side and multiplier-side signals of the arbiter in one bundle.
// The err signal exists only when MULT_ARB_TIMEOUT_EN is defined.
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 2
);

    logic [NREQ-1:0]      req;
    logic [NREQ*OP_W-1:0] op_a;
    logic [NREQ*OP_W-1:0] op_b;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [RES_W-1:0]     res;
`ifdef MULT_ARB_TIMEOUT_EN
    logic                 err;
`endif
    logic [OP_W-1:0]      m_a;
    logic [OP_W-1:0]      m_b;
    logic                 m_start;
    logic [RES_W-1:0]     m_res;
    logic                 m_busy;

    modport slave (
        input  req, op_a, op_b, m_res, m_busy,
`ifdef MULT_ARB_TIMEOUT_EN
        output err,
`endif
        output gnt, done, res, m_a, m_b, m_start
    );

    modport master (
        output req, op_a, op_b, m_res, m_busy,
`ifdef MULT_ARB_TIMEOUT_EN
        input  err,
`endif
        input  gnt, done, res, m_a, m_b, m_start
    );

endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request strictly after the
// pointer, wrapping modulo NREQ.
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int OW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [OW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [OW-1:0]   o_idx
);

    logic [OW-1:0]   w_cand [NREQ];
    logic [NREQ-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [OW:0] w_sum;
            assign w_sum       = {1'b0, i_ptr} + (OW+1)'(gi + 1);
            assign w_cand[gi]  = (w_sum >= (OW+1)'(NREQ)) ? OW'(w_sum - (OW+1)'(NREQ))
                                                           : OW'(w_sum);
            assign w_hit[gi]   = i_req[w_cand[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one `mult` unit between NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add the WAIT timeout abort and the err output.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);

    localparam int OW = idx_w(NREQ);

    arb_state_t       r_state, w_state_next;
    logic [NREQ-1:0]  r_gnt, w_gnt_next;
    logic [NREQ-1:0]  r_done, w_done_next;
    logic [RES_W-1:0] r_res, w_res_next;
    logic [OP_W-1:0]  r_m_a, w_m_a_next;
    logic [OP_W-1:0]  r_m_b, w_m_b_next;
    logic             r_m_start, w_m_start_next;
    logic [OW-1:0]    r_owner, w_owner_next;
    logic [OW-1:0]    r_ptr, w_ptr_next;
    logic             w_pick_valid;
    logic [OW-1:0]    w_pick_idx;
    logic [OP_W-1:0]  w_op_a [NREQ];
    logic [OP_W-1:0]  w_op_b [NREQ];

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] r_wait_cnt, w_wait_cnt_next;
    logic       r_err, w_err_next;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_op_a[gi] = bus.op_a[gi*OP_W +: OP_W];
            assign w_op_b[gi] = bus.op_b[gi*OP_W +: OP_W];
        end
    endgenerate

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_done     <= '0;
            r_res      <= '0;
            r_m_a      <= '0;
            r_m_b      <= '0;
            r_m_start  <= 1'b0;
            r_owner    <= '0;
            r_ptr      <= OW'(NREQ - 1);
`ifdef MULT_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_gnt      <= w_gnt_next;
            r_done     <= w_done_next;
            r_res      <= w_res_next;
            r_m_a      <= w_m_a_next;
            r_m_b      <= w_m_b_next;
            r_m_start  <= w_m_start_next;
            r_owner    <= w_owner_next;
            r_ptr      <= w_ptr_next;
`ifdef MULT_ARB_TIMEOUT_EN
            r_wait_cnt <= w_wait_cnt_next;
            r_err      <= w_err_next;
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_gnt_next      = '0;
        w_done_next     = '0;
        w_res_next      = r_res;
        w_m_a_next      = r_m_a;
        w_m_b_next      = r_m_b;
        w_m_start_next  = r_m_start;
        w_owner_next    = r_owner;
        w_ptr_next      = r_ptr;
`ifdef MULT_ARB_TIMEOUT_EN
        w_wait_cnt_next = r_wait_cnt;
        w_err_next      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_m_a_next             = w_op_a[w_pick_idx];
                    w_m_b_next             = w_op_b[w_pick_idx];
                    w_m_start_next         = 1'b1;
                    w_gnt_next[w_pick_idx] = 1'b1;
                    w_owner_next           = w_pick_idx;
                    w_ptr_next             = w_pick_idx;
                    w_state_next           = ISSUE;
                end
            end
            ISSUE: begin
                w_m_start_next = 1'b1;
                w_state_next   = SETTLE;
            end
            // m_busy may still be asserted from the previous job here.
            SETTLE: begin
                w_m_start_next  = 1'b0;
                w_state_next    = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                w_wait_cnt_next = '0;
`endif
            end
            WAIT: begin
                if (bus.m_busy) begin
                    w_res_next           = bus.m_res;
                    w_done_next[r_owner] = 1'b1;
                    w_state_next         = IDLE;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (r_wait_cnt == TO_LAST) begin
                    w_res_next           = '0;
                    w_done_next[r_owner] = 1'b1;
                    w_err_next           = 1'b1;
                    w_state_next         = IDLE;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                end
`endif
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.res     = r_res;
    assign bus.m_a     = r_m_a;
    assign bus.m_b     = r_m_b;
    assign bus.m_start = r_m_start;
`ifdef MULT_ARB_TIMEOUT_EN
    assign bus.err     = r_err;
`endif

    a_owner_range: assert property (@(posedge clk) disable iff (!rst)
        int'(r_owner) < NREQ);
    // The wait counter is 8 bits wide.
    a_timeout_range: assert property (@(posedge clk) disable iff (!rst)
        (TIMEOUT_CYC >= 1) && (TIMEOUT_CYC <= 256));

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural `mult` model.
// Define MULT_ARB_TIMEOUT_EN to also exercise the timeout abort.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int NREQ = 2;

    typedef struct {
        int idx;
        int res;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // mult model controls and state
    int   mdl_lat   = 3;
    bit   mdl_stale = 1'b0;
    int   mdl_cnt;
    int   mdl_pa, mdl_pb;
    logic mdl_start_d;
    logic mdl_clr;

    mult_arbiter_if #(.NREQ(NREQ)) bus ();

    mult_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at cycle %0d", name, got, exp, cyc);
        end
    endfunction

    // Behavioural mult: busy is result-valid, held until the next start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.m_busy  <= 1'b0;
            bus.m_res   <= '0;
            mdl_cnt     <= 0;
            mdl_start_d <= 1'b0;
            mdl_clr     <= 1'b0;
            mdl_pa      <= 0;
            mdl_pb      <= 0;
        end else begin
            mdl_start_d <= bus.m_start;
            if (bus.m_start && !mdl_start_d) begin
                mdl_pa  <= int'(bus.m_a);
                mdl_pb  <= int'(bus.m_b);
                mdl_cnt <= mdl_lat;
                if (mdl_stale) mdl_clr <= 1'b1;
                else           bus.m_busy <= 1'b0;
            end else begin
                if (mdl_clr) begin
                    bus.m_busy <= 1'b0;
                    mdl_clr    <= 1'b0;
                end
                if (mdl_cnt == 1) begin
                    bus.m_busy <= 1'b1;
                    bus.m_res  <= 14'(mdl_pa * mdl_pb);
                end
                if (mdl_cnt > 0) mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    // Monitor: checks every presented result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            if (bus.gnt != '0) begin
                chk("gnt_onehot", 32'($onehot(bus.gnt)), 1);
                chk("gnt_done_excl", 32'(bus.done), 0);
            end
            if (bus.done != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_owner", 32'(bus.done), 32'(1 << e.idx));
                    chk("res", 32'(bus.res), e.res);
`ifdef MULT_ARB_TIMEOUT_EN
                    chk("err", 32'(bus.err), 32'(e.err));
`endif
                    $display("done owner_mask=%0b res=%0d cycle=%0d", bus.done, bus.res, cyc);
                end
            end
        end
    end

    task automatic push_exp(input int idx, input int res, input bit err);
        exp_t e;
        e.idx = idx;
        e.res = res;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic run_job(input int idx, input int a, input int b, input int post_a,
                           input int exp_res, input bit exp_err, input int exp_lat);
        int n;
        int g_cyc;
        push_exp(idx, exp_res, exp_err);
        bus.op_a[idx*OP_W +: OP_W] = OP_W'(a);
        bus.op_b[idx*OP_W +: OP_W] = OP_W'(b);
        bus.req[idx] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.gnt[idx] !== 1'b1 && n < 100);
        chk("gnt_seen", 32'(bus.gnt[idx]), 1);
        g_cyc = cyc;
        chk("m_a_at_gnt", 32'(bus.m_a), a);
        chk("m_b_at_gnt", 32'(bus.m_b), b);
        chk("m_start_c0", 32'(bus.m_start), 1);
        bus.op_a[idx*OP_W +: OP_W] = OP_W'(post_a);
        bus.req[idx] = 1'b0;
        @(negedge clk);
        chk("m_start_c1", 32'(bus.m_start), 1);
        @(negedge clk);
        chk("m_start_c2", 32'(bus.m_start), 0);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.done[idx] !== 1'b1 && n < 100);
        chk("done_seen", 32'(bus.done[idx]), 1);
        chk("latency", cyc - g_cyc, exp_lat);
        $display("job req=%0d a=%0d b=%0d expect=%0d latency=%0d", idx, a, b, exp_res, cyc - g_cyc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n, k, g, last_d;
        rst      = 1'b0;
        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_res", 32'(bus.res), 0);
        chk("rst_m_start", 32'(bus.m_start), 0);
        chk("rst_m_a", 32'(bus.m_a), 0);
        chk("rst_m_b", 32'(bus.m_b), 0);
        rst = 1'b1;
        @(negedge clk);

        // Single job, then minimum-latency job on the other requester.
        mdl_lat = 3;
        run_job(0, 7, 3, 255, 21, 1'b0, 5);
        mdl_lat = 1;
        run_job(1, 6, 7, 0, 42, 1'b0, 3);

        // Contention: both held, expect 0,1,0,1 with one IDLE cycle between.
        mdl_lat = 3;
        bus.op_a = {8'd10, 8'd10};
        bus.op_b = {8'd10, 8'd10};
        for (int i = 0; i < 4; i++) push_exp(i % 2, 100, 1'b0);
        bus.req = 2'b11;
        k = 0; g = 0; n = 0; last_d = -1;
        while (k < 4 && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.gnt != '0) begin
                if (last_d >= 0) chk("idle_gap", cyc - last_d, 1);
                chk("gnt_order", 32'(bus.gnt), (g % 2 == 0) ? 1 : 2);
                g++;
            end
            if (bus.done != '0) begin
                k++;
                last_d = cyc;
                if (k == 4) bus.req = '0;
            end
        end
        chk("contention_dones", k, 4);
        repeat (2) @(negedge clk);
        chk("no_extra_gnt", 32'(bus.gnt), 0);

        // Operand change right after grant must not affect the result.
        run_job(0, 5, 6, 9, 30, 1'b0, 5);

        // Stale busy through ISSUE and SETTLE.
        mdl_stale = 1'b1;
        run_job(1, 4, 4, 0, 16, 1'b0, 5);
        mdl_stale = 1'b0;

        // Reset while in WAIT.
        mdl_lat = 6;
        bus.op_a[OP_W +: OP_W] = 8'd2;
        bus.op_b[OP_W +: OP_W] = 8'd3;
        bus.req[1] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.gnt[1] !== 1'b1 && n < 100);
        chk("gnt_before_rst", 32'(bus.gnt[1]), 1);
        bus.req[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_gnt", 32'(bus.gnt), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_res", 32'(bus.res), 0);
        chk("midrst_m_start", 32'(bus.m_start), 0);
        chk("midrst_m_a", 32'(bus.m_a), 0);
        chk("midrst_m_b", 32'(bus.m_b), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mdl_lat = 3;
        push_exp(0, 22, 1'b0);
        push_exp(1, 27, 1'b0);
        bus.op_a = {8'd3, 8'd11};
        bus.op_b = {8'd9, 8'd2};
        bus.req = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 100);
        chk("post_rst_first_gnt", 32'(bus.gnt), 1);
        chk("post_rst_m_a", 32'(bus.m_a), 11);
        bus.req[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 100);
        chk("post_rst_second_gnt", 32'(bus.gnt), 2);
        bus.req[1] = 1'b0;
        drain();

`ifdef MULT_ARB_TIMEOUT_EN
        // mult never answers: abort after 16 WAIT cycles, then normal service.
        mdl_lat = 0;
        run_job(0, 1, 1, 0, 0, 1'b1, 18);
        mdl_lat = 3;
        run_job(0, 3, 5, 0, 15, 1'b0, 5);
`endif

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
